// File: rtl/instruction_memory.sv
// instruction_memory: 256-byte program store loaded over a byte stream, then served combinationally to the core.
// Define IMEM_FILL_NOP_EN to return NOP_INSTR for fetches at or beyond the loaded length.
module instruction_memory #(
  parameter logic [7:0] NOP_INSTR = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       loadValid,
  input  logic [7:0] loadData,
  input  logic       loadLast,
  output logic       loadReady,
  input  logic       reload,
  input  logic [7:0] instructionAddress,
  output logic [7:0] instruction,
  output logic       cpuRun,
  output logic [8:0] loadCount
);
  typedef enum logic {LOAD, RUN} state_t;
  state_t     state_q, state_d;
  logic [8:0] count_q, count_d;
  logic [7:0] mem [0:255];
  logic       accept;
  logic [7:0] fetch;
  assign accept = (state_q == LOAD) && loadValid && !reload;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (reload) begin
      state_d = LOAD;
      count_d = '0;
    end else if (accept) begin
      count_d = count_q + 9'd1;
      state_d = (loadLast || count_q == 9'd255) ? RUN : LOAD;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= LOAD;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset && accept) mem[count_q[7:0]] <= loadData;
  end
`ifdef IMEM_FILL_NOP_EN
  assign fetch = ({1'b0, instructionAddress} < count_q) ? mem[instructionAddress] : NOP_INSTR;
`else
  assign fetch = mem[instructionAddress];
`endif
  assign loadReady   = state_q == LOAD;
  assign cpuRun      = state_q == RUN;
  assign instruction = cpuRun ? fetch : NOP_INSTR;
  assign loadCount   = count_q;
endmodule

// File: tb/tb_instruction_memory.sv
// tb_instruction_memory: directed load/fetch scenarios checked against a behavioural program-store model.
module tb_instruction_memory;
  logic       clock = 0;
  logic       reset = 1;
  logic       loadValid = 0;
  logic [7:0] loadData = 0;
  logic       loadLast = 0;
  logic       loadReady;
  logic       reload = 0;
  logic [7:0] instructionAddress = 0;
  logic [7:0] instruction;
  logic       cpuRun;
  logic [8:0] loadCount;
  int total = 0;
  int bad = 0;

  instruction_memory #(.NOP_INSTR(8'h00)) dut (
    .clock(clock), .reset(reset), .loadValid(loadValid), .loadData(loadData),
    .loadLast(loadLast), .loadReady(loadReady), .reload(reload),
    .instructionAddress(instructionAddress), .instruction(instruction),
    .cpuRun(cpuRun), .loadCount(loadCount)
  );

  always #5 clock = ~clock;

  function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: a program is a byte list; running means it has been terminated.
  logic [7:0] m_mem [0:255];
  bit         m_known [0:255];
  bit         m_run = 0;
  int         m_count = 0;
  bit         started = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_run = 0;
      m_count = 0;
      started = 1;
    end else if (reload) begin
      m_run = 0;
      m_count = 0;
    end else if (!m_run && loadValid) begin
      m_mem[m_count] = loadData;
      m_known[m_count] = 1;
      m_count = m_count + 1;
      if (loadLast || m_count == 256) m_run = 1;
    end
  end

  always @(negedge clock) begin
    if (started) begin
      check("loadReady", {15'd0, loadReady}, {15'd0, !m_run});
      check("cpuRun", {15'd0, cpuRun}, {15'd0, m_run});
      check("loadCount", {7'd0, loadCount}, m_count[15:0]);
      if (!m_run) check("instr_nop", {8'd0, instruction}, 16'h0000);
`ifdef IMEM_FILL_NOP_EN
      else if (int'(instructionAddress) >= m_count) check("instr_fill", {8'd0, instruction}, 16'h0000);
`endif
      else if (m_known[instructionAddress]) check("instr_mem", {8'd0, instruction}, {8'd0, m_mem[instructionAddress]});
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    loadValid = 1;
    loadData = d;
    loadLast = last;
    step();
    loadValid = 0;
    loadLast = 0;
  endtask

  task automatic fetch(input string name, input logic [7:0] a, input logic [7:0] exp);
    instructionAddress = a;
    #1;
    check(name, {8'd0, instruction}, {8'd0, exp});
  endtask

  initial begin
    step();
    step();
    reset = 0;
    step();
    check("idle_ready", {15'd0, loadReady}, 16'd1);
    check("idle_run", {15'd0, cpuRun}, 16'd0);
    check("idle_instr", {8'd0, instruction}, 16'h0000);
    check("idle_count", {7'd0, loadCount}, 16'd0);

    loadValid = 1;
    loadData = 8'h21;
    step();
    loadData = 8'h42;
    step();
    loadData = 8'hA5;
    loadLast = 1;
    step();
    loadValid = 0;
    loadLast = 0;
    check("p3_run", {15'd0, cpuRun}, 16'd1);
    check("p3_count", {7'd0, loadCount}, 16'd3);
    fetch("p3_a0", 8'd0, 8'h21);
    fetch("p3_a1", 8'd1, 8'h42);
    fetch("p3_a2", 8'd2, 8'hA5);
`ifdef IMEM_FILL_NOP_EN
    fetch("p3_a3_fill", 8'd3, 8'h00);
`endif
    step();

    reload = 1;
    step();
    reload = 0;
    check("rl_ready", {15'd0, loadReady}, 16'd1);
    check("rl_run", {15'd0, cpuRun}, 16'd0);
    check("rl_count", {7'd0, loadCount}, 16'd0);
    check("rl_instr", {8'd0, instruction}, 16'h0000);

    loadValid = 1;
    for (int i = 0; i < 256; i++) begin
      loadData = 8'(i);
      check("full_ready", {15'd0, loadReady}, 16'd1);
      step();
    end
    check("full_run", {15'd0, cpuRun}, 16'd1);
    check("full_count", {7'd0, loadCount}, 16'd256);
    fetch("full_aff", 8'hFF, 8'hFF);
    fetch("full_a03", 8'h03, 8'h03);
    loadData = 8'h99;
    step();
    step();
    loadValid = 0;
    check("full_hold", {7'd0, loadCount}, 16'd256);
    fetch("full_a00", 8'h00, 8'h00);

    reload = 1;
    step();
    reload = 0;
    send(8'h7E, 1);
    fetch("one_a0", 8'h00, 8'h7E);
    check("one_count", {7'd0, loadCount}, 16'd1);

    reload = 1;
    step();
    reload = 0;
    send(8'hAA, 0);
    send(8'hBB, 0);
    loadValid = 1;
    loadData = 8'hCC;
    reload = 1;
    step();
    reload = 0;
    loadValid = 0;
    check("rw_count", {7'd0, loadCount}, 16'd0);
    check("rw_ready", {15'd0, loadReady}, 16'd1);
    send(8'h11, 1);
    fetch("rw_a0", 8'h00, 8'h11);
`ifndef IMEM_FILL_NOP_EN
    fetch("rw_a1", 8'h01, 8'hBB);
    fetch("rw_a2", 8'h02, 8'h02);
`endif

    reload = 1;
    step();
    reload = 0;
    send(8'h31, 0);
    loadValid = 1;
    loadData = 8'h55;
    loadLast = 1;
    reset = 1;
    step();
    reset = 0;
    loadValid = 0;
    loadLast = 0;
    check("rst_run", {15'd0, cpuRun}, 16'd0);
    check("rst_count", {7'd0, loadCount}, 16'd0);
    check("rst_ready", {15'd0, loadReady}, 16'd1);
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
